// File: rtl/sram_bridge_1x2_pkg.sv
// Shared definitions for the 1-master / 2-slave SRAM bridge.
// Contents:
//   region_e   - decoded target of a request (none, data RAM, MMIO, unmapped)
//   DEF_*      - default base/mask constants for the two slave windows
package sram_bridge_1x2_pkg;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_S0   = 2'd1,
    REG_S1   = 2'd2,
    REG_BAD  = 2'd3
  } region_e;

  localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_S0_MASK = 32'hf000_0000;
  localparam logic [31:0] DEF_S1_BASE = 32'h1faf_0000;
  localparam logic [31:0] DEF_S1_MASK = 32'hffff_0000;

endpackage

// File: rtl/sram_addr_decode.sv
// Combinational address-to-region decoder.
// Ports:
//   addr   in  AW  request address
//   region out 2   REG_S1 / REG_S0 / REG_BAD (never REG_NONE)
// The MMIO window is checked first so it can sit inside the data-RAM window.
module sram_addr_decode
  import sram_bridge_1x2_pkg::*;
#(
  parameter int unsigned    AW      = 32,
  parameter logic [AW-1:0]  S0_BASE = AW'(DEF_S0_BASE),
  parameter logic [AW-1:0]  S0_MASK = AW'(DEF_S0_MASK),
  parameter logic [AW-1:0]  S1_BASE = AW'(DEF_S1_BASE),
  parameter logic [AW-1:0]  S1_MASK = AW'(DEF_S1_MASK)
) (
  input  logic [AW-1:0] addr,
  output region_e       region
);

  // Priority decode: MMIO window, then data RAM window, else unmapped
  always_comb begin
    region = REG_BAD;
    if ((addr & S1_MASK) == S1_BASE) begin
      region = REG_S1;
    end else if ((addr & S0_MASK) == S0_BASE) begin
      region = REG_S0;
    end else begin
      region = REG_BAD;
    end
  end

endmodule

// File: rtl/sram_bridge_1x2.sv
// Single-master to dual-slave SRAM-interface bridge.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   m_en/m_wen/m_addr/m_wdata   master request (wen all-zero = read)
//   m_rdata, m_err              response, one cycle after the request
//   sN_en                       per-slave request valid (combinational)
//   sN_wen/sN_addr/sN_wdata     request fields broadcast to both slaves
//   sN_rdata                    slave read data, valid the cycle after sN_en
//   err_clr                     clears err_sticky and bad_cnt
//   err_sticky/err_addr/bad_cnt unmapped-access debug status
// Requests decode combinationally; only the response select is registered,
// so back-to-back requests to either slave flow with no bubble.
module sram_bridge_1x2
  import sram_bridge_1x2_pkg::*;
#(
  parameter int unsigned    AW      = 32,
  parameter int unsigned    DW      = 32,
  parameter logic [AW-1:0]  S0_BASE = AW'(DEF_S0_BASE),
  parameter logic [AW-1:0]  S0_MASK = AW'(DEF_S0_MASK),
  parameter logic [AW-1:0]  S1_BASE = AW'(DEF_S1_BASE),
  parameter logic [AW-1:0]  S1_MASK = AW'(DEF_S1_MASK)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            m_en,
  input  logic [DW/8-1:0] m_wen,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_wdata,
  output logic [DW-1:0]   m_rdata,
  output logic            m_err,
  output logic            s0_en,
  output logic [DW/8-1:0] s0_wen,
  output logic [AW-1:0]   s0_addr,
  output logic [DW-1:0]   s0_wdata,
  input  logic [DW-1:0]   s0_rdata,
  output logic            s1_en,
  output logic [DW/8-1:0] s1_wen,
  output logic [AW-1:0]   s1_addr,
  output logic [DW-1:0]   s1_wdata,
  input  logic [DW-1:0]   s1_rdata,
  input  logic            err_clr,
  output logic            err_sticky,
  output logic [AW-1:0]   err_addr,
  output logic [7:0]      bad_cnt
);

  region_e           region_s;
  region_e           rsel_r;
  logic              bad_req_s;
  logic [DW-1:0]     m_rdata_s;
  logic              err_sticky_r;
  logic [AW-1:0]     err_addr_r;
  logic [7:0]        bad_cnt_r;

  sram_addr_decode #(
    .AW      (AW),
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK)
  ) u_decode (
    .addr   (m_addr),
    .region (region_s)
  );

  assign bad_req_s = m_en && (region_s == REG_BAD);

  // Request path: enables gated by decode, other fields broadcast unchanged
  assign s0_en    = m_en && (region_s == REG_S0);
  assign s1_en    = m_en && (region_s == REG_S1);
  assign s0_wen   = m_wen;
  assign s1_wen   = m_wen;
  assign s0_addr  = m_addr;
  assign s1_addr  = m_addr;
  assign s0_wdata = m_wdata;
  assign s1_wdata = m_wdata;

  // Response select: remembers which slave owes data next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsel_r <= REG_NONE;
    end else if (m_en) begin
      rsel_r <= region_s;
    end else begin
      rsel_r <= REG_NONE;
    end
  end

  // Response mux: unmapped and idle cycles return zero data
  always_comb begin
    m_rdata_s = {DW{1'b0}};
    case (rsel_r)
      REG_S0:  m_rdata_s = s0_rdata;
      REG_S1:  m_rdata_s = s1_rdata;
      default: m_rdata_s = {DW{1'b0}};
    endcase
  end

  assign m_rdata = m_rdata_s;
  assign m_err   = (rsel_r == REG_BAD);

  // Error capture: a new unmapped access takes precedence over err_clr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_sticky_r <= 1'b0;
      err_addr_r   <= {AW{1'b0}};
      bad_cnt_r    <= 8'd0;
    end else if (bad_req_s) begin
      // With err_clr the old capture is discarded, so this address is "first"
      if (!err_sticky_r || err_clr) begin
        err_addr_r <= m_addr;
      end else begin
        err_addr_r <= err_addr_r;
      end
      err_sticky_r <= 1'b1;
      if (err_clr) begin
        bad_cnt_r <= 8'd1;
      end else if (bad_cnt_r != 8'hff) begin
        bad_cnt_r <= bad_cnt_r + 8'd1;
      end else begin
        bad_cnt_r <= bad_cnt_r;
      end
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
      bad_cnt_r    <= 8'd0;
    end else begin
      err_sticky_r <= err_sticky_r;
      bad_cnt_r    <= bad_cnt_r;
    end
  end

  assign err_sticky = err_sticky_r;
  assign err_addr   = err_addr_r;
  assign bad_cnt    = bad_cnt_r;

endmodule

// File: tb/tb_sram_bridge_1x2.sv
// Self-checking bench for sram_bridge_1x2: directed test-plan items plus a
// randomized phase, all checked against a behavioural model of the bridge.
module tb_sram_bridge_1x2;

  logic        clk;
  logic        resetn;
  logic        m_en;
  logic [3:0]  m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        s0_en, s1_en;
  logic [3:0]  s0_wen, s1_wen;
  logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
  logic [31:0] s0_rdata, s1_rdata;
  logic        err_clr;
  logic        err_sticky;
  logic [31:0] err_addr;
  logic [7:0]  bad_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: target of the request in flight (0 idle,1 ram,2 mmio,3 bad)
  int          exp_prev   = 0;
  logic        exp_sticky = 1'b0;
  logic [31:0] exp_addr   = 32'd0;
  int          exp_cnt    = 0;

  sram_bridge_1x2 dut (
    .clk        (clk),
    .resetn     (resetn),
    .m_en       (m_en),
    .m_wen      (m_wen),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_err      (m_err),
    .s0_en      (s0_en),
    .s0_wen     (s0_wen),
    .s0_addr    (s0_addr),
    .s0_wdata   (s0_wdata),
    .s0_rdata   (s0_rdata),
    .s1_en      (s1_en),
    .s1_wen     (s1_wen),
    .s1_addr    (s1_addr),
    .s1_wdata   (s1_wdata),
    .s1_rdata   (s1_rdata),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .bad_cnt    (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Address map from the region rules: mmio window first, then 256MB RAM
  function automatic int target_of(input logic [31:0] a);
    if (a >= 32'h1faf_0000 && a <= 32'h1faf_ffff) return 2;
    else if (a < 32'h1000_0000) return 1;
    else return 3;
  endfunction

  task automatic check_status();
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, exp_sticky});
    chk("err_addr", err_addr, exp_addr);
    chk("bad_cnt", {24'd0, bad_cnt}, exp_cnt);
  endtask

  // One bus cycle: drive at negedge, check outputs, advance the model
  task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic clr,
                     input logic [31:0] d0, input logic [31:0] d1);
    int t;
    logic [31:0] exp_rd;
    @(negedge clk);
    m_en = en; m_wen = wen; m_addr = addr; m_wdata = wdata; err_clr = clr;
    s0_rdata = d0; s1_rdata = d1;
    #1;
    t = target_of(addr);
    chk("s0_en", {31'd0, s0_en}, {31'd0, (en && t == 1)});
    chk("s1_en", {31'd0, s1_en}, {31'd0, (en && t == 2)});
    chk("s0_addr", s0_addr, addr);
    chk("s1_addr", s1_addr, addr);
    chk("s0_wen", {28'd0, s0_wen}, {28'd0, wen});
    chk("s1_wdata", s1_wdata, wdata);
    exp_rd = (exp_prev == 1) ? d0 : (exp_prev == 2) ? d1 : 32'd0;
    chk("m_rdata", m_rdata, exp_rd);
    chk("m_err", {31'd0, m_err}, {31'd0, (exp_prev == 3)});
    check_status();
    // state after the coming rising edge
    exp_prev = en ? t : 0;
    if (en && t == 3) begin
      if (!exp_sticky || clr) exp_addr = addr;
      exp_sticky = 1'b1;
      exp_cnt = clr ? 1 : ((exp_cnt + 1 > 255) ? 255 : exp_cnt + 1);
    end else if (clr) begin
      exp_sticky = 1'b0;
      exp_cnt = 0;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 3);
    case (sel)
      0: r = r & 32'h0fff_fffc;
      1: r = 32'h1faf_0000 | (r & 32'h0000_fffc);
      2: r = r | 32'h1000_0000;
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    resetn = 1'b0; m_en = 1'b0; m_wen = 4'd0; m_addr = 32'd0; m_wdata = 32'd0;
    err_clr = 1'b0; s0_rdata = 32'h1111_1111; s1_rdata = 32'h2222_2222;
    #1;
    chk("rst m_rdata", m_rdata, 32'd0);
    chk("rst m_err", {31'd0, m_err}, 32'd0);
    check_status();
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // RAM read
    cyc(1'b1, 4'd0, 32'h0000_1000, 32'd0, 1'b0, $urandom, $urandom);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'hdead_beef, 32'h5555_5555);
    // MMIO then RAM back to back
    cyc(1'b1, 4'd0, 32'h1faf_f020, 32'd0, 1'b0, $urandom, $urandom);
    cyc(1'b1, 4'd0, 32'h0000_0004, 32'd0, 1'b0, 32'h0bad_0000, 32'h1234_0001);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'h0000_abcd, 32'h9999_9999);
    // Unmapped write, then a second unmapped access
    cyc(1'b1, 4'b0011, 32'h8000_0000, 32'hcafe_f00d, 1'b0, $urandom, $urandom);
    cyc(1'b1, 4'd0, 32'h9000_0000, 32'd0, 1'b0, $urandom, $urandom);
    idle();
    // Saturation, then clear coinciding with a new error
    for (int i = 0; i < 260; i++)
      cyc(1'b1, 4'd0, 32'hf000_0000 + i * 4, 32'd0, 1'b0, $urandom, $urandom);
    idle();
    chk("bad_cnt sat", {24'd0, bad_cnt}, 32'h0000_00ff);
    cyc(1'b1, 4'd0, 32'ha000_0000, 32'd0, 1'b1, $urandom, $urandom);
    idle();
    chk("clr+bad addr", err_addr, 32'ha000_0000);
    chk("clr+bad cnt", {24'd0, bad_cnt}, 32'd1);
    // Clear alone keeps the captured address
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, $urandom, $urandom);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) != 0), 4'($urandom), rand_addr(), $urandom,
          ($urandom_range(0, 15) == 0), $urandom, $urandom);
    cyc(1'b1, 4'd0, 32'h7000_0000, 32'd0, 1'b0, $urandom, $urandom);

    // Reset in the cycle after an MMIO read
    cyc(1'b1, 4'd0, 32'h1faf_0010, 32'd0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    m_en = 1'b0;
    s1_rdata = 32'h1234_5678;
    #1;
    chk("pre-rst m_rdata", m_rdata, 32'h1234_5678);
    resetn = 1'b0;
    #1;
    exp_prev = 0; exp_sticky = 1'b0; exp_addr = 32'd0; exp_cnt = 0;
    chk("mid-rst m_rdata", m_rdata, 32'd0);
    chk("mid-rst m_err", {31'd0, m_err}, 32'd0);
    check_status();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 4'd0, rand_addr(), $urandom, 1'b0, $urandom, $urandom);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bridge_1x2.md
# sram_bridge_1x2

Single-master to dual-slave SRAM-interface bridge. It sits between the CPU data-side SRAM port and two fixed-latency slaves: slave 0 is the data RAM and slave 1 is the confreg/MMIO block. It decodes each request address, steers the request to exactly one slave, and returns that slave's read data to the master one cycle later. Unmapped accesses are absorbed locally, flagged with an error pulse, and the first offending address is captured for debug.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; byte-enable width is DW/8
- S0_BASE, 32'h0000_0000, slave 0 region base
- S0_MASK, 32'hf000_0000, slave 0 region mask
- S1_BASE, 32'h1faf_0000, slave 1 region base
- S1_MASK, 32'hffff_0000, slave 1 region mask

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- m_en  in  1  master request valid
- m_wen  in  DW/8  byte write enables; all zero means read
- m_addr  in  AW  request address
- m_wdata  in  DW  write data
- m_rdata  out  DW  read data, valid the cycle after the request
- m_err  out  1  one-cycle pulse, aligned with m_rdata, for an unmapped access
- s0_en / s1_en  out  1  per-slave request valid
- s0_wen / s1_wen  out  DW/8  byte enables, broadcast
- s0_addr / s1_addr  out  AW  address, broadcast
- s0_wdata / s1_wdata  out  DW  write data, broadcast
- s0_rdata / s1_rdata  in  DW  slave read data, valid the cycle after that slave's en
- err_clr  in  1  clears err_sticky and bad_cnt
- err_sticky  out  1  set by any unmapped access
- err_addr  out  AW  address of the first unmapped access since the last clear
- bad_cnt  out  8  unmapped-access count, saturates at 8'hff

## Operation
- Decode priority:
  - S1 hit if (m_addr & S1_MASK) == S1_BASE.
  - Otherwise S0 hit if (m_addr & S0_MASK) == S0_BASE.
  - Otherwise BAD.
- Request path is combinational. sN_en = m_en & hitN. wen, addr and wdata go to both slaves unchanged.
- Response select register rsel has four states: NONE, S0, S1, BAD. Each cycle, rsel <= m_en ? decode(m_addr) : NONE.
- m_rdata by rsel:
  - S0 gives s0_rdata.
  - S1 gives s1_rdata.
  - NONE and BAD give all zeros.
- m_err = (rsel == BAD). It is combinational from rsel, so it is a one-cycle pulse.
- BAD write: no slave is enabled, so the data is dropped; m_err still pulses.
- Error capture on a BAD request at the clock edge:
  - If err_sticky is 0: err_addr <= m_addr and err_sticky <= 1.
  - bad_cnt increments, saturating at 8'hff.
- err_clr alone: err_sticky <= 0 and bad_cnt <= 0; err_addr holds its value.
- err_clr together with a BAD request in the same cycle: the new error wins. err_sticky = 1, err_addr = the new address, bad_cnt = 1.

## Timing
- Reset values: rsel = NONE, m_rdata = 0, m_err = 0, err_sticky = 0, err_addr = 0, bad_cnt = 0.
- sN_en and the other slave outputs follow the master inputs combinationally, so they are 0 while m_en = 0.
- Latency is 1 cycle, request to m_rdata/m_err. There is no stall and no backpressure; one request per cycle is accepted.
- Back-to-back requests to alternating slaves: each response is selected independently, with no bubble.
- Reset asserted mid-operation: rsel clears immediately, so m_rdata = 0 and m_err = 0 in the following cycle regardless of the request in flight.

## Structure
- Shared package holds:
  - the region enum (NONE, S0, S1, BAD), 2 bits;
  - the default base/mask constants.
- Sub-module sram_addr_decode: combinational address to region decode, instantiated once.
- Top level holds rsel, the response mux, and the error capture/counter logic.

## Test plan
- Read to 32'h0000_1000 with s0_rdata = 32'hdead_beef next cycle -> s0_en = 1, s1_en = 0; next cycle m_rdata = 32'hdead_beef, m_err = 0.
- Read 32'h1faf_f020 followed immediately by a read of 32'h0000_0004 -> s1_en then s0_en on consecutive cycles; m_rdata = s1_rdata then s0_rdata.
- Write m_wen = 4'b0011 to 32'h8000_0000 -> s0_en = s1_en = 0; next cycle m_err = 1, m_rdata = 0, err_addr = 32'h8000_0000, err_sticky = 1, bad_cnt = 1.
- Second BAD access at 32'h9000_0000 -> err_addr stays 32'h8000_0000, bad_cnt = 2.
- 260 consecutive BAD accesses -> bad_cnt = 8'hff. Then err_clr asserted with a BAD access at 32'ha000_0000 in the same cycle -> err_sticky = 1, err_addr = 32'ha000_0000, bad_cnt = 1.
- resetn dropped in the cycle after an S1 read -> m_rdata = 0 and m_err = 0 immediately; all status outputs are 0.
